// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack sequencer: command codes, FSM states and
// the SP-block op codes it drives.
package stack_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int SFR_OP_LEN = 2;

  localparam logic [SFR_OP_LEN-1:0] OP_SP_NONE = 2'd0;
  localparam logic [SFR_OP_LEN-1:0] OP_SP_PUSH = 2'd1;
  localparam logic [SFR_OP_LEN-1:0] OP_SP_POP  = 2'd2;

  typedef enum logic [1:0] {
    STK_PUSH = 2'd0,
    STK_POP  = 2'd1,
    STK_CALL = 2'd2,
    STK_RET  = 2'd3
  } stk_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADJ  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4
  } stk_state_e;

  function automatic logic [1:0] cmd_bytes(input stk_cmd_e c);
    return (c == STK_CALL || c == STK_RET) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic is_push_type(input stk_cmd_e c);
    return (c == STK_PUSH || c == STK_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer: orders SP adjust-then-write for PUSH/CALL and
// read-then-adjust for POP/RET against an external SP block and RAM.
//
// state | meaning
// IDLE  | ready for a command
// ADJ   | ask SP block to pre-decrement (push op)
// WR    | write current byte at adjusted SP
// RD    | read RAM at current SP
// CAP   | capture read byte, ask SP block to post-increment (pop op)
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = 2 * DATA_W,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic [1:0]            i_cmd,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [PC_W-1:0]       i_pc,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [DATA_W-1:0]     o_data,
  output logic [PC_W-1:0]       o_pc,
  output logic [SFR_OP_LEN-1:0] o_sp_op,
  input  logic [ADDR_W-1:0]     i_sp,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic                  o_ram_wr,
  output logic [DATA_W-1:0]     o_ram_wdata,
  output logic                  o_ram_rd,
  input  logic [DATA_W-1:0]     i_ram_rdata
);

  stk_state_e        state_q;
  stk_cmd_e          cmd_q;
  logic [1:0]        cnt_q;
  logic [PC_W-1:0]   wbuf_q;
  logic [DATA_W-1:0] rbuf_q;
  logic              done_q;
  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= STK_PUSH;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            cmd_q   <= stk_cmd_e'(i_cmd);
            cnt_q   <= cmd_bytes(stk_cmd_e'(i_cmd));
            // CALL shifts out low byte first; PUSH only ever uses the low byte
            wbuf_q  <= (stk_cmd_e'(i_cmd) == STK_CALL) ? i_pc
                                                       : {{(PC_W-DATA_W){1'b0}}, i_data};
            rbuf_q  <= '0;
            state_q <= is_push_type(stk_cmd_e'(i_cmd)) ? ST_ADJ : ST_RD;
          end
        end
        ST_ADJ: state_q <= ST_WR;
        ST_WR: begin
          wbuf_q <= wbuf_q >> DATA_W;
          cnt_q  <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ADJ;
          end
        end
        ST_RD: state_q <= ST_CAP;
        ST_CAP: begin
          rbuf_q <= i_ram_rdata;
          cnt_q  <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            // RET pops the high byte first, so it already sits in rbuf_q
            if (cmd_q == STK_POP) data_q <= i_ram_rdata;
            else                  pc_q   <= {rbuf_q, i_ram_rdata};
          end else begin
            state_q <= ST_RD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by reset so an aborted command issues nothing more
  assign o_ready     = (state_q == ST_IDLE);
  assign o_done      = done_q;
  assign o_data      = data_q;
  assign o_pc        = pc_q;
  assign o_sp_op     = i_rst                ? OP_SP_NONE :
                       (state_q == ST_ADJ)  ? OP_SP_PUSH :
                       (state_q == ST_CAP)  ? OP_SP_POP  : OP_SP_NONE;
  assign o_ram_wr    = !i_rst && (state_q == ST_WR);
  assign o_ram_rd    = !i_rst && (state_q == ST_RD);
  assign o_ram_addr  = (state_q == ST_WR || state_q == ST_RD) ? i_sp : '0;
  assign o_ram_wdata = wbuf_q[DATA_W-1:0];

endmodule
